// File: rtl/nios_system_nios2_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_nios2_mul_seq
// Brief    : Two-requester sequential multiplier sharing one registered 16x16
//            multiplier. Operands are split into 16-bit halves and partial
//            products are accumulated over several cycles. Ties between
//            requesters are resolved round-robin or by fixed priority.
//            Optional macro NIOS_SYSTEM_NIOS2_MUL_SEQ_HIGH_EN enables the
//            a_hi*b_hi partial and a full 64-bit product on rsp_hi.
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_nios2_mul_seq #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    input  logic        rsp_ready
);

`ifdef NIOS_SYSTEM_NIOS2_MUL_SEQ_HIGH_EN
    localparam int         c_acc_w    = 64;
    localparam logic [1:0] c_last_idx = 2'd3;
`else
    localparam int         c_acc_w    = 32;
    localparam logic [1:0] c_last_idx = 2'd2;
`endif

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_flush = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_id;
    logic               r_pref;
    logic [31:0]        r_prod;
    logic [1:0]         r_pidx;
    logic [c_acc_w-1:0] r_acc;

    logic               w_both;
    logic               w_grant_id;
    logic               w_idle_ok;
    logic               w_xfer;
    logic [15:0]        w_op_a;
    logic [15:0]        w_op_b;
    logic [31:0]        w_mul;
    logic [c_acc_w-1:0] w_part;

    // Arbitration: a lone valid requester wins; a tie goes to the preferred one
    always_comb begin
        w_both     = req0_valid & req1_valid;
        w_grant_id = 1'b0;
        if (w_both)
            w_grant_id = (FIXED_PRIORITY != 0) ? 1'b0 : r_pref;
        else if (req1_valid)
            w_grant_id = 1'b1;
        w_idle_ok  = (r_state == c_idle) & ~reset;
        req0_ready = w_idle_ok & req0_valid & ~w_grant_id;
        req1_ready = w_idle_ok & req1_valid &  w_grant_id;
        w_xfer     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
    end

    // Operand-half selection for the partial issued this cycle
    always_comb begin
        w_op_a = r_a[15:0];
        w_op_b = r_b[15:0];
        case (r_cnt)
            2'd0:    begin w_op_a = r_a[15:0];  w_op_b = r_b[15:0];  end
            2'd1:    begin w_op_a = r_a[15:0];  w_op_b = r_b[31:16]; end
            2'd2:    begin w_op_a = r_a[31:16]; w_op_b = r_b[15:0];  end
            default: begin w_op_a = r_a[31:16]; w_op_b = r_b[31:16]; end
        endcase
    end

    assign w_mul = 32'(w_op_a) * 32'(w_op_b);

    // Align the registered product by the weight of the partial it came from
    always_comb begin
`ifdef NIOS_SYSTEM_NIOS2_MUL_SEQ_HIGH_EN
        case (r_pidx)
            2'd0:    w_part = {32'd0, r_prod};
            2'd3:    w_part = {r_prod, 32'd0};
            default: w_part = {16'd0, r_prod, 16'd0};
        endcase
`else
        if (r_pidx == 2'd0)
            w_part = r_prod;
        else
            w_part = {r_prod[15:0], 16'd0};
`endif
    end

    // Control FSM, operand capture, multiplier pipeline and accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
            r_cnt   <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_id    <= 1'b0;
            r_pref  <= 1'b0;
            r_prod  <= 32'd0;
            r_pidx  <= 2'd0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_xfer) begin
                        r_a     <= w_grant_id ? req1_a : req0_a;
                        r_b     <= w_grant_id ? req1_b : req0_b;
                        r_id    <= w_grant_id;
                        r_pref  <= ~w_grant_id;
                        r_acc   <= '0;
                        r_cnt   <= 2'd0;
                        r_state <= c_issue;
                    end
                end
                c_issue: begin
                    r_prod <= w_mul;
                    r_pidx <= r_cnt;
                    // The first issue cycle has no product in flight yet
                    if (r_cnt != 2'd0)
                        r_acc <= r_acc + w_part;
                    if (r_cnt == c_last_idx)
                        r_state <= c_flush;
                    else
                        r_cnt <= r_cnt + 2'd1;
                end
                c_flush: begin
                    r_acc   <= r_acc + w_part;
                    r_state <= c_resp;
                end
                default: begin
                    if (rsp_ready)
                        r_state <= c_idle;
                end
            endcase
        end
    end

    // Response outputs are only driven while a result is being presented
    always_comb begin
        rsp_valid = (r_state == c_resp);
        rsp_id    = rsp_valid ? r_id : 1'b0;
        rsp_lo    = rsp_valid ? r_acc[31:0] : 32'd0;
`ifdef NIOS_SYSTEM_NIOS2_MUL_SEQ_HIGH_EN
        rsp_hi    = rsp_valid ? r_acc[63:32] : 32'd0;
`else
        rsp_hi    = 32'd0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_nios2_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_nios2_mul_seq
// Brief    : Self-checking bench for nios_system_nios2_mul_seq. Expected
//            results come from plain 64-bit arithmetic and a simple
//            last-served arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_system_nios2_mul_seq;

`ifdef NIOS_SYSTEM_NIOS2_MUL_SEQ_HIGH_EN
    localparam int c_lat     = 6;
    localparam bit c_high_en = 1'b1;
`else
    localparam int c_lat     = 5;
    localparam bit c_high_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_a = 32'd0;
    logic [31:0] req0_b = 32'd0;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_a = 32'd0;
    logic [31:0] req1_b = 32'd0;
    logic        req0_ready;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_ready = 1'b1;

    logic        fp_req0_valid = 1'b0;
    logic        fp_req1_valid = 1'b0;
    logic        fp_req0_ready;
    logic        fp_req1_ready;
    logic        fp_rsp_valid;
    logic        fp_rsp_id;
    logic [31:0] fp_rsp_lo;
    logic [31:0] fp_rsp_hi;

    int checks   = 0;
    int failures = 0;
    bit last_served = 1'b1;   // reset state favours req0

    always #5 clk = ~clk;

    nios_system_nios2_mul_seq #(.FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_ready(rsp_ready)
    );

    nios_system_nios2_mul_seq #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(fp_req0_valid), .req0_a(32'd11), .req0_b(32'd13),
        .req1_valid(fp_req1_valid), .req1_a(32'd17), .req1_b(32'd19),
        .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
        .rsp_valid(fp_rsp_valid), .rsp_id(fp_rsp_id),
        .rsp_lo(fp_rsp_lo), .rsp_hi(fp_rsp_hi), .rsp_ready(1'b1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rv"}, rsp_valid, 0);
        check({tag, "_r0"}, req0_ready, 0);
        check({tag, "_r1"}, req1_ready, 0);
        check({tag, "_id"}, rsp_id, 0);
        check({tag, "_lo"}, rsp_lo, 0);
        check({tag, "_hi"}, rsp_hi, 0);
    endtask

    // One complete operation: offer, expect the modelled grant, wait, compare
    task automatic run_op(input string tag, input bit v0, input bit v1,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input int stall);
        bit          g;
        logic [63:0] prod;
        int          n;
        logic        sid;
        logic [31:0] slo, shi;
        g = (v0 && v1) ? ~last_served : v1;
        prod = g ? 64'(a1) * 64'(b1) : 64'(a0) * 64'(b0);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = (stall == 0);
        #1;
        check({tag, "_rdy0"}, req0_ready, v0 && !g);
        check({tag, "_rdy1"}, req1_ready, v1 && g);
        step();
        last_served = g;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_lat"}, n, c_lat);
        check({tag, "_id"}, rsp_id, g);
        check({tag, "_lo"}, rsp_lo, prod[31:0]);
        check({tag, "_hi"}, rsp_hi, c_high_en ? prod[63:32] : 32'd0);
        sid = rsp_id; slo = rsp_lo; shi = rsp_hi;
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, "_hold_rv"}, rsp_valid, 1);
            check({tag, "_hold_lo"}, {rsp_id, rsp_lo, rsp_hi}, {sid, slo, shi});
            check({tag, "_hold_rdy"}, {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        step();
        check({tag, "_done"}, rsp_valid, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        last_served = 1'b1;
        step();
    endtask

    initial begin
        // Reset state with valids asserted
        apply_reset();

        // Basic product with carry into the upper word
        run_op("basic", 1, 0, 32'h00012345, 32'h00010000, 0, 0, 0);

        // All-ones operands
        run_op("ones", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);

        // Both valid straight out of reset: req0 first, then req1
        apply_reset();
        run_op("both_a", 1, 1, 32'd2, 32'd3, 32'd5, 32'd7, 0);
        run_op("both_b", 0, 1, 32'd2, 32'd3, 32'd5, 32'd7, 0);

        // Long back-pressure, then a transfer immediately in the next idle cycle
        run_op("stall", 0, 1, 32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678, 10);
        run_op("after_stall", 1, 0, 32'h8000_0001, 32'h0001_FFFF, 0, 0, 0);

        // Reset in the second cycle after a transfer aborts the operation
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
        step();
        req0_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_idle_outputs("midrst");
        step();
        reset = 1'b0;
        last_served = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("midrst_norsp", rsp_valid, 0);
        end
        run_op("post_rst", 1, 1, 32'h0000_FFFF, 32'h0000_FFFF, 32'd3, 32'd4, 0);

        // Randomised traffic against the arithmetic/arbitration model
        for (int i = 0; i < 24; i++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            run_op("rand", v0, v1, $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3));
        end

        // Fixed priority: req1 must never be granted while req0 stays valid
        fp_req0_valid = 1'b1;
        fp_req1_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            check("fp_r1_ready", fp_req1_ready, 0);
            if (fp_rsp_valid) begin
                check("fp_id", fp_rsp_id, 0);
                check("fp_lo", fp_rsp_lo, 32'd143);
            end
            step();
        end
        fp_req0_valid = 1'b0;
        fp_req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
